// File: rtl/rf_pkg.sv
// Shared constants, address typedef and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_NUM_WR        = 2;
    localparam int unsigned RF_DEPTH_DEFAULT = 32;
    localparam int unsigned RF_AW_DEFAULT    = $clog2(RF_DEPTH_DEFAULT);
    localparam int unsigned RF_HELPER_AW     = 32;

    typedef logic [RF_AW_DEFAULT-1:0] rf_addr_t;

    // True when the address names the hardwired zero register.
    function automatic logic rf_is_zero_reg(input logic [RF_HELPER_AW-1:0] addr,
                                            input logic                    zero_en);
        return zero_en && (addr == '0);
    endfunction

    // True when the address refers to an implemented register.
    function automatic logic rf_in_range(input logic [RF_HELPER_AW-1:0] addr,
                                         input int unsigned             depth);
        return addr < RF_HELPER_AW'(depth);
    endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, set wins on collision.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RF_NUM_WR-1:0]           wr_en,
    input  logic [RF_NUM_WR-1:0][AW-1:0]   wr_addr,
    input  logic                           issue_en,
    input  logic [AW-1:0]                  issue_addr,
    output logic [DEPTH-1:0]               pend,
    output logic                           pending_any
);

    logic [DEPTH-1:0] pend_nxt;

    // Clears first, then the issue set, so the newer producer stays outstanding.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < RF_NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k] == AW'(i))) begin
                    pend_nxt[i] = 1'b0;
                end
            end
            if (issue_en && (issue_addr == AW'(i))) begin
                pend_nxt[i] = 1'b1;
            end
            if (rf_is_zero_reg(RF_HELPER_AW'(i), ZERO_REG != 0)) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            pending_any <= 1'b0;
        end else begin
            pend        <= pend_nxt;
            pending_any <= |pend_nxt;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// optional zero register and pending scoreboard. Optional same-cycle write
// bypass on the read ports is enabled by defining RF_WRITE_BYPASS_EN.
module register_file_mp
    import rf_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RF_NUM_WR-1:0]            wr_en,
    input  logic [RF_NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [RF_NUM_WR-1:0][WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0][AW-1:0]       rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]               rd_pending,
    input  logic                            issue_en,
    input  logic [AW-1:0]                   issue_addr,
    output logic                            pending_any
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("register_file_mp: DEPTH must be at least 2");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_pow2
        $error("register_file_mp: DEPTH must be a power of two");
    end
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_rd
        $error("register_file_mp: NUM_RD must be 1 to 4");
    end

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;

    // Flop-based storage; port 1 wins a same-address write conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!rf_is_zero_reg(RF_HELPER_AW'(i), ZERO_REG != 0)) begin
                    if (wr_en[1] && (wr_addr[1] == AW'(i))) begin
                        regs[i] <= wr_data[1];
                    end else if (wr_en[0] && (wr_addr[0] == AW'(i))) begin
                        regs[i] <= wr_data[0];
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .pend        (pend),
        .pending_any (pending_any)
    );

    // Read muxes; unmatched addresses fall through to zero.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r]    = '0;
            rd_pending[r] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[r] == AW'(i)) begin
                    rd_data[r]    = regs[i];
                    rd_pending[r] = pend[i];
                end
            end
`ifdef RF_WRITE_BYPASS_EN
            // Forward the write landing this edge; the zero register is never forwarded.
            if (!rst && !rf_is_zero_reg(RF_HELPER_AW'(rd_addr[r]), ZERO_REG != 0)
                && rf_in_range(RF_HELPER_AW'(rd_addr[r]), DEPTH)) begin
                if (wr_en[1] && (wr_addr[1] == rd_addr[r])) begin
                    rd_data[r]    = wr_data[1];
                    rd_pending[r] = 1'b0;
                end else if (wr_en[0] && (wr_addr[0] == rd_addr[r])) begin
                    rd_data[r]    = wr_data[0];
                    rd_pending[r] = 1'b0;
                end
            end
`endif
            if (rf_is_zero_reg(RF_HELPER_AW'(rd_addr[r]), ZERO_REG != 0)) begin
                rd_data[r]    = '0;
                rd_pending[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vectors plus random traffic
// against an array-based model of the register file and scoreboard.
`timescale 1ns/1ps
module tb_register_file_mp;
    import rf_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_pending;
    logic             issue_en;
    rf_addr_t         issue_addr;
    logic             pending_any;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    register_file_mp dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .pending_any (pending_any)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state update: port 0 then port 1 so port 1 wins; issue after clears.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) begin
                    m_regs[wr_addr[k]] = wr_data[k];
                    m_pend[wr_addr[k]] = 1'b0;
                end
            end
            if (issue_en) m_pend[issue_addr] = 1'b1;
            m_regs[0] = 32'h0;
            m_pend[0] = 1'b0;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
        if (wr_en[1] && wr_addr[1] == a) return wr_data[1];
        if (wr_en[0] && wr_addr[0] == a) return wr_data[0];
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        if ((wr_en[1] && wr_addr[1] == a) || (wr_en[0] && wr_addr[0] == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic exp_any();
        logic any = 1'b0;
        for (int i = 0; i < 32; i++) any |= m_pend[i];
        return any;
    endfunction

    // Compare process: every cycle, well after inputs settle and before the edge.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0) begin
            for (int r = 0; r < 2; r++) begin
                check($sformatf("model rd_data[%0d] x%0d", r, rd_addr[r]),
                      rd_data[r], exp_data(rd_addr[r]));
                check($sformatf("model rd_pending[%0d] x%0d", r, rd_addr[r]),
                      32'(rd_pending[r]), 32'(exp_pend(rd_addr[r])));
            end
            check("model pending_any", 32'(pending_any), 32'(exp_any()));
        end
    end

    task automatic idle();
        wr_en    = 2'b00;
        issue_en = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr[0] = 5'($urandom_range(0, 31));
            wr_addr[1] = ($urandom_range(0, 3) == 0) ? wr_addr[0] : 5'($urandom_range(0, 31));
            wr_data[0] = $urandom();
            wr_data[1] = $urandom();
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr[0] : 5'($urandom_range(0, 31));
            rd_addr[0] = ($urandom_range(0, 2) == 0) ? wr_addr[1] : 5'($urandom_range(0, 31));
            rd_addr[1] = 5'($urandom_range(0, 31));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0; issue_addr = '0;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
        repeat (3) @(negedge clk);
        check("reset rd_data[0]", rd_data[0], 32'h0);
        check("reset pending_any", 32'(pending_any), 32'h0);
        rst = 1'b0;
        #1;
        check("post-reset rd_data[1]", rd_data[1], 32'h0);

        // Basic write x5
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        @(negedge clk); idle(); #1;
        check("write x5", rd_data[0], 32'hDEADBEEF);

        // Write conflict on x7
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        @(negedge clk); idle(); #1;
        check("conflict x7", rd_data[1], 32'h22222222);

        // Zero register
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        @(negedge clk); idle(); rd_addr[0] = 5'd0; #1;
        check("x0 rd_data", rd_data[0], 32'h0);
        check("x0 rd_pending", 32'(rd_pending[0]), 32'h0);
        check("x0 pending_any", 32'(pending_any), 32'h0);

        // Scoreboard sequencing on x3
        issue_en = 1'b1; issue_addr = 5'd3;
        @(negedge clk); idle(); rd_addr[1] = 5'd3; #1;
        check("issue x3 pending", 32'(rd_pending[1]), 32'h1);
        check("issue x3 any", 32'(pending_any), 32'h1);
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
        @(negedge clk); idle(); #1;
        check("write x3 clears", 32'(rd_pending[1]), 32'h0);
        check("write x3 any", 32'(pending_any), 32'h0);
        wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h34;
        issue_en = 1'b1; issue_addr = 5'd3;
        @(negedge clk); idle(); #1;
        check("issue+write x3 set wins", 32'(rd_pending[1]), 32'h1);
        check("issue+write x3 any", 32'(pending_any), 32'h1);
        check("issue+write x3 data", rd_data[1], 32'h34);
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h35;
        @(negedge clk); idle();

        // Same-cycle read of a write to x9
        rd_addr[0] = 5'd9;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h0000ABCD;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("bypass x9 same cycle", rd_data[0], 32'h0000ABCD);
`else
        check("no bypass x9 same cycle", rd_data[0], 32'h0);
`endif
        @(negedge clk); idle(); #1;
        check("x9 next cycle", rd_data[0], 32'h0000ABCD);

        random_cycles(300);

        // Fill x1..x31, issue x4, then reset between edges
        for (int a = 1; a < 32; a += 2) begin
            @(negedge clk);
            issue_en = 1'b0;
            wr_en = (a + 1 < 32) ? 2'b11 : 2'b01;
            wr_addr[0] = 5'(a); wr_data[0] = $urandom();
            wr_addr[1] = 5'(a + 1); wr_data[1] = $urandom();
        end
        @(negedge clk);
        idle(); issue_en = 1'b1; issue_addr = 5'd4;
        @(negedge clk);
        idle(); rd_addr[1] = 5'd4; #1;
        check("x4 pending before reset", 32'(rd_pending[1]), 32'h1);
        check("any before reset", 32'(pending_any), 32'h1);
        #2;
        wr_en = 2'b11; wr_addr[0] = 5'd6; wr_addr[1] = 5'd8; issue_en = 1'b1; issue_addr = 5'd6;
        rst = 1'b1;
        for (int a = 0; a < 32; a += 2) begin
            rd_addr[0] = 5'(a); rd_addr[1] = 5'(a + 1);
            #1;
            check($sformatf("mid reset rd_data x%0d", a), rd_data[0], 32'h0);
            check($sformatf("mid reset rd_data x%0d", a + 1), rd_data[1], 32'h0);
            check("mid reset rd_pending", 32'(rd_pending), 32'h0);
        end
        check("mid reset pending_any", 32'(pending_any), 32'h0);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        random_cycles(200);
        @(negedge clk); idle();
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file.
- Supports configurable width, depth and read-port count, two write ports, a hardwired zero register and a per-register pending scoreboard for hazard detection.
- Sits between decode (read and issue side) and writeback (write side) of the RISC-V core.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of registers; must be a power of two and at least 2
NUM_RD, 2, number of read ports (1 to 4)
ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and issues

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
wr_en  input  [1:0]  write enable, one bit per write port
wr_addr  input  [1:0][AW-1:0]  write address per port, where AW = $clog2(DEPTH)
wr_data  input  [1:0][WIDTH-1:0]  write data per port
rd_addr  input  [NUM_RD-1:0][AW-1:0]  read addresses
rd_data  output  [NUM_RD-1:0][WIDTH-1:0]  read data
rd_pending  output  [NUM_RD-1:0]  pending bit of each addressed register
issue_en  input  1  mark a destination register as pending
issue_addr  input  [AW-1:0]  destination register to mark pending
pending_any  output  1  OR of all pending bits

Behaviour:
- Reset (asynchronous, on assertion of rst):
  - All registers clear to 0 and all pending bits clear to 0.
  - Consequently rd_data = 0, rd_pending = 0 and pending_any = 0 while rst is high.
  - Reset asserted mid-cycle clears state immediately, discarding any in-flight write or issue.
- Reads:
  - Combinational: rd_data[i] = regs[rd_addr[i]].
  - rd_pending[i] = pend[rd_addr[i]].
- Writes:
  - Committed on the rising clock edge; the new value is readable in the next cycle.
- Write conflict (both ports enabled with the same address): port 1 wins.
- Zero register (ZERO_REG = 1):
  - Writes to address 0 are dropped.
  - rd_data for address 0 is forced to 0.
  - The pending bit of register 0 never sets, so it always reads 0.
- Scoreboard:
  - issue_en sets pend[issue_addr] on the clock edge.
  - Any wr_en[k] to address a clears pend[a] on the clock edge.
  - Issue and write to the same address in the same cycle: set wins, because the newer producer is outstanding.
  - Issue of an already-pending register leaves the bit set; there is no counting.
- pending_any: registered OR of the next-state pending vector, so it is valid in the same cycle the bits update.
- Out-of-range addresses (when DEPTH is not a full 2^AW): reads return 0, writes are ignored, issues are ignored.
- Storage must infer flops, not block RAM, because of the asynchronous reset.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- When defined:
  - If a read address matches an enabled write address in the same cycle, rd_data returns wr_data combinationally.
  - Port 1 has priority over port 0.
  - rd_pending returns 0 for that address, reflecting the clear.
  - Register 0 is never bypassed.
- When undefined:
  - Reads return the pre-edge stored value.
  - rd_pending returns the stored bit.

Decomposition:
- Package rf_pkg holds:
  - Constant RF_NUM_WR = 2.
  - The typedef rf_addr_t, defined with the $clog2(DEPTH) expression via parameterised usage.
  - A shared function for the zero-register check.
- One sub-module: rf_scoreboard, containing the pending vector, the set/clear priority logic and pending_any.
- The storage array and read muxes stay in the top module.

Test Plan:
- Reset and basic write: hold rst high for 3 cycles, then write 0xDEADBEEF to x5 on port 0 and read x5 next cycle -> rd_data = 0xDEADBEEF. Before the write, all reads return 0 and pending_any = 0.
- Write conflict: port 0 writes 0x11111111 and port 1 writes 0x22222222, both to x7 -> x7 reads 0x22222222.
- Zero register: write 0xFFFFFFFF to x0 and issue x0 -> rd_data = 0, rd_pending = 0, pending_any = 0.
- Scoreboard sequencing:
  - Issue x3 -> rd_pending = 1 and pending_any = 1 next cycle.
  - Write x3 -> pending clears.
  - Issue and write x3 in the same cycle -> pending stays 1.
- Bypass, with RF_WRITE_BYPASS_EN defined: write 0x0000ABCD to x9 while reading x9 -> same-cycle rd_data = 0x0000ABCD. Without the macro -> old value 0.
- Reset mid-operation: fill x1..x31 with random values, issue x4, then assert rst asynchronously between clock edges -> all rd_data = 0 and pending_any = 0 immediately. A golden model compared against random traffic shows no mismatches.
